// File: rtl/imem_cache_if.sv
// Bundle of the fetch-side (PCF/InstrF) and main-memory-side signals of imem_cache.
interface imem_cache_if;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    // Memory handshake: while mem_req=1 the cache holds mem_addr stable; a word is
    // accepted on each rising edge with mem_valid=1. mem_valid is ignored while mem_req=0.
    modport slave (
        input  pc, flush, mem_rdata, mem_valid,
        output instr, stall, mem_req, mem_addr
    );

    modport master (
        output pc, flush, mem_rdata, mem_valid,
        input  instr, stall, mem_req, mem_addr
    );
endinterface

// File: rtl/imem_cache.sv
// Direct-mapped read-only instruction cache with whole-line refill over a req/valid handshake.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module imem_cache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    imem_cache_if.slave       bus,
    output logic              state_dbg_o
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OB  = $clog2(WORDS);
    localparam int IB  = $clog2(LINES);
    localparam int OBW = (OB > 0) ? OB : 1;
    localparam int TGW = 30 - OB - IB;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TGW-1:0]   tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];
    logic [31:0]      base_q;
    logic [OBW-1:0]   k_q;
    logic             flush_pend_q;

    logic [31:0]    word_addr;
    logic [OBW-1:0] lk_off;
    logic [IB-1:0]  lk_idx;
    logic [TGW-1:0] lk_tag;
    logic [IB-1:0]  ref_idx;
    logic [TGW-1:0] ref_tag;
    logic [31:0]    line_base;
    logic           hit;
    logic           last_word;
    logic           fill_done;

    // Address split of the live fetch address and of the latched refill base.
    assign word_addr = {2'b00, bus.pc[31:2]};
    assign lk_off    = OBW'(word_addr & 32'(WORDS - 1));
    assign lk_idx    = IB'((word_addr >> OB) & 32'(LINES - 1));
    assign lk_tag    = TGW'(bus.pc >> (2 + OB + IB));
    assign ref_idx   = IB'((base_q >> (2 + OB)) & 32'(LINES - 1));
    assign ref_tag   = TGW'(base_q >> (2 + OB + IB));
    assign line_base = bus.pc & ~32'((WORDS * 4) - 1);

    assign hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign last_word = (k_q == OBW'(WORDS - 1));
    assign fill_done = (state_q == REFILL) && bus.mem_valid && last_word;

    assign state_dbg_o = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!hit) state_d = REFILL;
            REFILL:  if (bus.mem_valid && last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.stall    = 1'b1;
        bus.instr    = 32'h0;
        bus.mem_req  = 1'b0;
        bus.mem_addr = 32'h0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    bus.stall = 1'b0;
                    bus.instr = data_q[lk_idx][lk_off];
                end
            end
            REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = base_q | (32'(k_q) << 2);
            end
            default: ;
        endcase
    end

    // A flush seen at any point of a refill keeps the filled line invalid at completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q       <= '0;
            k_q          <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                flush_pend_q <= 1'b0;
                if (!hit) begin
                    base_q <= line_base;
                    k_q    <= '0;
                end
            end else begin
                if (bus.flush) flush_pend_q <= 1'b1;
                if (bus.mem_valid) k_q <= k_q + OBW'(1);
            end
            if (bus.flush) valid_q <= '0;
            if (fill_done) valid_q[ref_idx] <= !(bus.flush || flush_pend_q);
        end
    end

    // Tag and data arrays are storage only; validity is governed by valid_q.
    always_ff @(posedge clk) begin
        if ((state_q == REFILL) && bus.mem_valid) begin
            data_q[ref_idx][k_q] <= bus.mem_rdata;
        end
        if (fill_done) begin
            tag_q[ref_idx] <= ref_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (!hit && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_imem_cache.sv
// Self-checking bench for imem_cache: directed scenarios plus randomized fetches against a
// line-level reference model (valid/tag per line, memory word = its own address).
module tb_imem_cache;
  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int LINE_BYTES = WORDS * 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic state_dbg;

  imem_cache_if bus();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  imem_cache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state_dbg_o(state_dbg)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails = 0;

  // Reference model: which memory line each cache slot currently holds.
  bit mv[LINES];
  logic [31:0] ml[LINES];
  logic [31:0] exp_q[$];

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return mv[m_idx(a)] && (ml[m_idx(a)] == (a / LINE_BYTES));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One fetch of address a. mode: 0 zero-wait memory, 1 valid every 3rd cycle, 2 random waits.
  // flush_k: -1 none, -2 flush in the lookup cycle, 0..WORDS-1 flush in the refill cycle with that k.
  task automatic do_fetch(input logic [31:0] a, input int mode, input int flush_k);
    bit hit;
    bit v;
    bit flushed;
    int rc;
    int k;
    logic [31:0] base;
    bus.pc = a;
    bus.flush = (flush_k == -2);
    bus.mem_valid = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    @(negedge clk);
    hit = m_hit(a);
    chk("lookup_stall", {31'b0, bus.stall}, hit ? 32'd0 : 32'd1);
    chk("lookup_instr", bus.instr, hit ? {a[31:2], 2'b00} : 32'h0);
    if (hit) chk("hit_mem_req", {31'b0, bus.mem_req}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.mem_valid = 1'b0;
    if (flush_k == -2) m_clear();
    if (!hit) begin
      base = a & ~32'(LINE_BYTES - 1);
      for (int i = 0; i < WORDS; i++) exp_q.push_back(base + 32'(4 * i));
      rc = 0;
      flushed = 1'b0;
      while (exp_q.size() > 0 && rc < 200) begin
        @(negedge clk);
        chk("refill_stall", {31'b0, bus.stall}, 32'd1);
        chk("refill_req", {31'b0, bus.mem_req}, 32'd1);
        chk("refill_instr", bus.instr, 32'h0);
        chk("refill_addr", bus.mem_addr, exp_q[0]);
        case (mode)
          0: v = 1'b1;
          1: v = ((rc % 3) == 2);
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        bus.mem_valid = v;
        bus.mem_rdata = v ? exp_q[0] : $urandom;
        k = WORDS - exp_q.size();
        if (k == flush_k && !flushed) begin
          bus.flush = 1'b1;
          flushed = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.mem_valid = 1'b0;
        if (v) void'(exp_q.pop_front());
        rc++;
      end
      if (exp_q.size() != 0) begin
        chk("refill_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
      if (flushed) m_clear();
      mv[m_idx(a)] = !flushed;
      ml[m_idx(a)] = a / LINE_BYTES;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int r;
    int fk;
    bus.pc = 32'h0;
    bus.flush = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 32'h0;
    m_clear();

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_stall", {31'b0, bus.stall}, 32'd1);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_state", {31'b0, state_dbg}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Cold miss, then same-line hits.
    do_fetch(32'h0000_0010, 0, -1);
    do_fetch(32'h0000_0010, 0, -1);
    do_fetch(32'h0000_001C, 0, -1);

    // Conflict replacement at the same index.
    do_fetch(32'h0000_0000, 0, -1);
    do_fetch(32'h0000_0100, 0, -1);
    do_fetch(32'h0000_0000, 0, -1);

    // Wait states: valid every third cycle.
    do_fetch(32'h0000_0204, 1, -1);
    do_fetch(32'h0000_0208, 0, -1);

    // Flush during refill at k=2, then the same pc misses again.
    do_fetch(32'h0000_0300, 0, 2);
    do_fetch(32'h0000_0300, 0, -1);
    do_fetch(32'h0000_0304, 0, -1);

    // Flush in IDLE on a hit: same-cycle hit, then everything misses.
    do_fetch(32'h0000_0308, 0, -2);
    do_fetch(32'h0000_0308, 2, -1);

    // Randomized fetches with occasional flushes.
    for (int n = 0; n < 150; n++) begin
      a = 32'($urandom_range(0, 511)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      r = $urandom_range(0, 19);
      fk = (r == 0) ? -2 : (r == 1) ? int'($urandom_range(0, WORDS - 1)) : -1;
      do_fetch(a, int'($urandom_range(0, 2)), fk);
    end

    // Reset mid-refill at k=1.
    bus.pc = 32'h0010_0040;
    @(negedge clk);
    chk("mrst_miss", {31'b0, bus.stall}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mrst_addr0", bus.mem_addr, 32'h0010_0040);
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'h0010_0040;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mrst_addr1", bus.mem_addr, 32'h0010_0044);
    bus.mem_rdata = 32'h0010_0044;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_req", {31'b0, bus.mem_req}, 32'd0);
    chk("mrst_state", {31'b0, state_dbg}, 32'd0);
    m_clear();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    bus.mem_valid = 1'b0;
    reset = 1'b1;

    // One miss then three hits on the same line.
    do_fetch(32'h0010_0044, 0, -1);
    do_fetch(32'h0010_0044, 0, -1);
    do_fetch(32'h0010_0040, 0, -1);
    do_fetch(32'h0010_004C, 0, -1);
`ifdef ICACHE_STATS_EN
    chk("stats_miss", miss_count, 32'd1);
    chk("stats_hit", hit_count, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
